// File: rtl/object_scheduler.sv
// -----------------------------------------------------------------------------
// object_scheduler
//
// Walks the object buffer once per frame and hands each object to the
// downstream rasterizer through a valid/ready handshake.
//
// A pass runs:
//   CLEAR (rewind cursor) -> FETCH -> PRESENT -> ADVANCE -> FETCH ... -> DONE
// It ends after the object flagged as last, or after SIZE accepted objects if
// no last flag is ever seen.
//
// Every output is a flop. The strobes for a state are decoded from the next
// state, so they are high during the cycle spent in that state. frame_done is
// decoded from the current state, so it appears in the cycle after DONE, while
// the FSM is already back in IDLE. A frame_start that coincides with that pulse
// is therefore treated as an overrun and does not start a pass.
//
// Parameters:
//   SIZE      object buffer capacity; it bounds the objects emitted per pass
//   object_t  object payload type
//
// Ports:
//   clock           single clock, rising edge
//   reset           synchronous, active-low
//   frame_start     one-cycle pulse that starts a pass
//   buf_empty       the buffer holds no objects
//   buf_data        buffer entry at the read cursor (combinational)
//   buf_read_end    the read cursor is at the last written object
//   buf_read        cursor-advance strobe (buffer acts on its rising edge)
//   buf_next_frame  cursor-rewind strobe
//   obj_data        object presented downstream
//   obj_valid       obj_data is valid
//   obj_ready       downstream accepts the object
//   frame_done      one-cycle pulse when a pass completes
//   overrun         sticky: frame_start arrived while the block was busy
//
// Optional feature (macro OBJECT_SCHEDULER_STATS_EN):
//   stat_objects    objects accepted in the last completed pass
//   stat_stall      PRESENT cycles with obj_ready low in the last completed
//                   pass (16 bit, saturating)
// -----------------------------------------------------------------------------
module object_scheduler #(
    parameter int  SIZE     = 50,
    parameter type object_t = logic [31:0]
) (
    input  logic    clock,
    input  logic    reset,
    input  logic    frame_start,
    input  logic    buf_empty,
    input  object_t buf_data,
    input  logic    buf_read_end,
    output logic    buf_read,
    output logic    buf_next_frame,
    output object_t obj_data,
    output logic    obj_valid,
    input  logic    obj_ready,
    output logic    frame_done,
    output logic    overrun
`ifdef OBJECT_SCHEDULER_STATS_EN
    ,
    output logic [$clog2(SIZE):0] stat_objects,
    output logic [15:0]           stat_stall
`endif
);

    localparam int IDX_W = $clog2(SIZE);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] SIZE_C = CNT_W'(SIZE);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FETCH,
        PRESENT,
        ADVANCE,
        DONE
    } state_t;

    state_t           state_reg, state_next;
    logic             last_reg, last_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             overrun_reg, overrun_next;
    object_t          obj_data_reg, obj_data_next;
    logic             obj_valid_reg, obj_valid_next;
    logic             buf_read_reg, buf_read_next;
    logic             buf_next_frame_reg, buf_next_frame_next;
    logic             frame_done_reg, frame_done_next;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg          <= IDLE;
            last_reg           <= 1'b0;
            count_reg          <= '0;
            overrun_reg        <= 1'b0;
            obj_data_reg       <= '0;
            obj_valid_reg      <= 1'b0;
            buf_read_reg       <= 1'b0;
            buf_next_frame_reg <= 1'b0;
            frame_done_reg     <= 1'b0;
        end else begin
            state_reg          <= state_next;
            last_reg           <= last_next;
            count_reg          <= count_next;
            overrun_reg        <= overrun_next;
            obj_data_reg       <= obj_data_next;
            obj_valid_reg      <= obj_valid_next;
            buf_read_reg       <= buf_read_next;
            buf_next_frame_reg <= buf_next_frame_next;
            frame_done_reg     <= frame_done_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        last_next     = last_reg;
        count_next    = count_reg;
        overrun_next  = overrun_reg;
        obj_data_next = obj_data_reg;

        case (state_reg)
            IDLE: begin
                if (frame_start) begin
                    // The previous pass is still signalling completion.
                    if (frame_done_reg) begin
                        overrun_next = 1'b1;
                    end else begin
                        state_next = CLEAR;
                    end
                end
            end
            CLEAR: begin
                count_next = '0;
                last_next  = 1'b0;
                state_next = buf_empty ? DONE : FETCH;
            end
            FETCH: begin
                obj_data_next = buf_data;
                last_next     = buf_read_end;
                state_next    = PRESENT;
            end
            PRESENT: begin
                if (obj_valid_reg && obj_ready) begin
                    count_next = count_reg + CNT_W'(1);
                    // Stop after SIZE objects even if no last flag was seen.
                    if (last_reg || (count_next == SIZE_C)) begin
                        state_next = DONE;
                    end else begin
                        state_next = ADVANCE;
                    end
                end
            end
            ADVANCE: state_next = FETCH;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase

        // A start request while busy is dropped and only recorded.
        if (frame_start && (state_reg != IDLE)) begin
            overrun_next = 1'b1;
        end

        buf_next_frame_next = (state_next == CLEAR);
        obj_valid_next      = (state_next == PRESENT);
        buf_read_next       = (state_next == ADVANCE);
        frame_done_next     = (state_reg == DONE);
    end

    assign buf_read       = buf_read_reg;
    assign buf_next_frame = buf_next_frame_reg;
    assign obj_data       = obj_data_reg;
    assign obj_valid      = obj_valid_reg;
    assign frame_done     = frame_done_reg;
    assign overrun        = overrun_reg;

`ifdef OBJECT_SCHEDULER_STATS_EN
    logic [CNT_W-1:0] stat_objects_reg;
    logic [15:0]      stat_stall_reg;
    logic [15:0]      stall_cnt_reg;

    always_ff @(posedge clock) begin
        if (!reset) begin
            stat_objects_reg <= '0;
            stat_stall_reg   <= '0;
            stall_cnt_reg    <= '0;
        end else begin
            case (state_reg)
                CLEAR: stall_cnt_reg <= '0;
                PRESENT: begin
                    if (!obj_ready && (stall_cnt_reg != 16'hFFFF)) begin
                        stall_cnt_reg <= stall_cnt_reg + 16'd1;
                    end
                end
                // Published from DONE so the values are visible with frame_done.
                DONE: begin
                    stat_objects_reg <= count_reg;
                    stat_stall_reg   <= stall_cnt_reg;
                end
                default: ;
            endcase
        end
    end

    assign stat_objects = stat_objects_reg;
    assign stat_stall   = stat_stall_reg;
`endif

endmodule

// File: tb/tb_object_scheduler.sv
// -----------------------------------------------------------------------------
// tb_object_scheduler
//
// Randomised and directed passes over a small buffer model. Expected waveforms
// for each pass come from a schedule computed from the timing rules:
//   - first object valid 3 cycles after the start
//   - an object stays valid until the first cycle with ready high
//   - buf_read follows in the next cycle
//   - the next object is valid 3 cycles after acceptance
//   - frame_done comes 2 cycles after the final acceptance (cycle 3 when empty)
// Stats checks are compiled in when OBJECT_SCHEDULER_STATS_EN is defined.
// -----------------------------------------------------------------------------
module tb_object_scheduler;

    localparam int SIZE = 4;

    logic        clock       = 1'b0;
    logic        reset       = 1'b0;
    logic        frame_start = 1'b0;
    logic        obj_ready   = 1'b0;
    logic        buf_empty;
    logic        buf_read_end;
    logic [31:0] buf_data;
    logic        buf_read;
    logic        buf_next_frame;
    logic [31:0] obj_data;
    logic        obj_valid;
    logic        frame_done;
    logic        overrun;
`ifdef OBJECT_SCHEDULER_STATS_EN
    logic [$clog2(SIZE):0] stat_objects;
    logic [15:0]           stat_stall;
`endif

    object_scheduler #(.SIZE(SIZE)) dut (
        .clock          (clock),
        .reset          (reset),
        .frame_start    (frame_start),
        .buf_empty      (buf_empty),
        .buf_data       (buf_data),
        .buf_read_end   (buf_read_end),
        .buf_read       (buf_read),
        .buf_next_frame (buf_next_frame),
        .obj_data       (obj_data),
        .obj_valid      (obj_valid),
        .obj_ready      (obj_ready),
        .frame_done     (frame_done),
        .overrun        (overrun)
`ifdef OBJECT_SCHEDULER_STATS_EN
        ,
        .stat_objects   (stat_objects),
        .stat_stall     (stat_stall)
`endif
    );

    always #5 clock = ~clock;

    // ---------------- buffer model ----------------
    logic [31:0] mem [16];
    int          depth      = 0;
    bit          tie0       = 1'b0;
    int          cursor     = 0;
    logic        buf_read_q = 1'b0;

    assign buf_data     = mem[cursor[3:0]];
    assign buf_empty    = (depth == 0);
    assign buf_read_end = !tie0 && (depth != 0) && (cursor == depth - 1);

    always @(posedge clock) begin
        buf_read_q <= buf_read;
        if (buf_next_frame) cursor <= 0;
        else if (buf_read && !buf_read_q) cursor <= cursor + 1;
    end

    // ---------------- checking ----------------
    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference schedule ----------------
    // ctl bits: {overrun, frame_done, buf_read, buf_next_frame, obj_valid}
    logic [4:0]  exp_ctl [256];
    logic [31:0] exp_dat [256];
    bit          exp_dv  [256];
    bit          rdy     [256];
    bit          ovr_model = 1'b0;

    task automatic build_model(input int d, input bit t0, input int extra_k, input int rst_k,
                               output int done_cyc, output int n, output int stalls);
        int t;
        int a;
        for (int k = 0; k < 256; k++) begin
            exp_ctl[k] = '0;
            exp_dv[k]  = 1'b0;
            exp_dat[k] = '0;
        end
        if (d == 0)      n = 0;
        else if (t0)     n = SIZE;
        else             n = (d < SIZE) ? d : SIZE;
        stalls   = 0;
        done_cyc = 3;
        exp_ctl[1][1] = 1'b1;
        t = 3;
        for (int i = 0; i < n; i++) begin
            a = t;
            while (!rdy[a]) a++;
            for (int k = t; k <= a; k++) begin
                exp_ctl[k][0] = 1'b1;
                exp_dv[k]     = 1'b1;
                exp_dat[k]    = mem[i];
            end
            stalls += a - t;
            if (i < n - 1) begin
                exp_ctl[a+1][2] = 1'b1;
                t = a + 3;
            end else begin
                done_cyc = a + 2;
            end
        end
        exp_ctl[done_cyc][3] = 1'b1;
        for (int k = 0; k < 256; k++)
            exp_ctl[k][4] = ovr_model || ((extra_k > 0) && (k > extra_k));
        if (rst_k >= 0) begin
            for (int k = rst_k + 1; k < 256; k++) begin
                exp_ctl[k] = '0;
                exp_dv[k]  = 1'b0;
            end
        end
    endtask

    // extra_in: -1 none, -2 random busy cycle, -3 the frame_done cycle, >0 cycle
    task automatic run_pass(input string name, input int d, input bit t0,
                            input int extra_in, input int rst_k);
        int done_cyc;
        int n;
        int stalls;
        int extra_k;
        int last;
        depth = d;
        tie0  = t0;
        build_model(d, t0, -1, rst_k, done_cyc, n, stalls);
        extra_k = extra_in;
        if (extra_in == -2) extra_k = $urandom_range(1, done_cyc);
        if (extra_in == -3) extra_k = done_cyc;
        build_model(d, t0, extra_k, rst_k, done_cyc, n, stalls);
        last = ((rst_k >= 0) ? rst_k : done_cyc) + 3;
        for (int k = 0; k <= last; k++) begin
            @(negedge clock);
            check($sformatf("%s c%0d ctl", name, k),
                  {59'd0, overrun, frame_done, buf_read, buf_next_frame, obj_valid},
                  {59'd0, exp_ctl[k]});
            if (exp_dv[k])
                check($sformatf("%s c%0d data", name, k), {32'd0, obj_data}, {32'd0, exp_dat[k]});
            frame_start = (k == 0) || (k == extra_k);
            obj_ready   = rdy[k];
            reset       = (k == rst_k) ? 1'b0 : 1'b1;
        end
        frame_start = 1'b0;
        reset       = 1'b1;
`ifdef OBJECT_SCHEDULER_STATS_EN
        check({name, " stat_objects"}, 64'(stat_objects), (rst_k >= 0) ? 64'd0 : 64'(n));
        check({name, " stat_stall"},   64'(stat_stall),   (rst_k >= 0) ? 64'd0 : 64'(stalls));
`endif
        if (rst_k >= 0)        ovr_model = 1'b0;
        else if (extra_k > 0)  ovr_model = 1'b1;
        $display("pass %s depth=%0d tie0=%0d objs=%0d stalls=%0d done_cycle=%0d extra=%0d rst=%0d",
                 name, d, t0, n, stalls, done_cyc, extra_k, rst_k);
    endtask

    task automatic ready_fill(input bit v);
        for (int k = 0; k < 256; k++) rdy[k] = v;
    endtask

    task automatic ready_random();
        for (int k = 0; k < 256; k++) rdy[k] = (k >= 100) || ($urandom_range(0, 9) < 7);
    endtask

    task automatic mem_random();
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
    endtask

    initial begin
        int d;
        int rst_k;
        int extra;
        mem_random();
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check("reset ctl",  {59'd0, overrun, frame_done, buf_read, buf_next_frame, obj_valid}, 64'd0);
        check("reset data", {32'd0, obj_data}, 64'd0);
`ifdef OBJECT_SCHEDULER_STATS_EN
        check("reset stat_objects", 64'(stat_objects), 64'd0);
        check("reset stat_stall",   64'(stat_stall),   64'd0);
`endif
        reset = 1'b1;

        ready_fill(1'b1);
        run_pass("two_obj", 2, 1'b0, -1, -1);

        ready_fill(1'b1);
        for (int k = 3; k <= 12; k++) rdy[k] = 1'b0;
        run_pass("stall10", 2, 1'b0, -1, -1);

        ready_fill(1'b1);
        run_pass("empty", 0, 1'b0, -1, -1);

        ready_fill(1'b1);
        for (int k = 3; k <= 5; k++) rdy[k] = 1'b0;
        run_pass("restart_in_present", 2, 1'b0, 4, -1);

        ready_fill(1'b1);
        run_pass("reset_in_advance", 2, 1'b0, -1, 4);
        run_pass("after_reset", 2, 1'b0, -1, -1);

        run_pass("end_tied_low", 3, 1'b1, -1, -1);

        run_pass("start_on_done", 2, 1'b0, -3, -1);

        for (int p = 0; p < 40; p++) begin
            mem_random();
            ready_random();
            d     = $urandom_range(0, 7);
            extra = ($urandom_range(0, 3) == 0) ? -2 : -1;
            rst_k = -1;
            if ($urandom_range(0, 7) == 0) begin
                rst_k = $urandom_range(1, 12);
                extra = -1;
            end
            run_pass($sformatf("rand%0d", p), d, ($urandom_range(0, 4) == 0), extra, rst_k);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
